pc_gen: RTL and testbench

PC_GEN -- requirements
Module: pc_gen

---
 rtl/pc_gen.sv | 124 ++++++++++++
 tb/tb_pc_gen.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// Fetch-PC generator: sequential fetch, D-stage branch/jump/eret redirects,
// exception vectoring, and a one-deep pending redirect for cycles without a fetch ack.
module pc_gen #(
  parameter logic [31:0] RESET_PC    = 32'h0000_3000,
  parameter logic [31:0] EXC_VEC     = 32'h0000_4180,
  parameter logic [31:0] ERET_OFFSET = 32'd4,
  parameter bit          DELAY_SLOT  = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        imem_ack,
  input  logic        stall,
  input  logic        req,
  input  logic        eret_D,
  input  logic [31:0] epc,
  input  logic [2:0]  npc_op_D,
  input  logic [31:0] instr_D,
  input  logic [31:0] pc_D,
  input  logic [31:0] rs_val_D,
  input  logic        cmp_true_D,
  output logic [31:0] pc_F,
  output logic        flush_F,
  output logic        pend_v,
  output logic        op_err,
  output logic [15:0] redirect_cnt
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;
  logic        pend_v_q, pend_v_d;
  logic        op_err_q, op_err_d;
  logic [15:0] cnt_q, cnt_d;

  logic [31:0] base;
  logic [31:0] d_target;
  logic        taken;
  logic        d_redir;
  logic        advance;
  logic        applied;

  logic unused_instr_hi;
  assign unused_instr_hi = ^instr_D[31:26];

  assign base    = pc_D + 32'd4;
  assign advance = imem_ack & ~stall;

  always_comb begin
    taken    = 1'b0;
    d_target = base;
    if (eret_D) begin
      d_target = epc + ERET_OFFSET;
    end else begin
      unique case (npc_op_D)
        3'b001: begin
          taken    = cmp_true_D;
          d_target = base + {{14{instr_D[15]}}, instr_D[15:0], 2'b00};
        end
        3'b010: begin
          taken    = 1'b1;
          d_target = {base[31:28], instr_D[25:0], 2'b00};
        end
        3'b011: begin
          taken    = 1'b1;
          d_target = rs_val_D;
        end
        default: taken = 1'b0;  // 000 and illegal 1xx behave as no redirect
      endcase
    end
  end

  // A stalled D stage is re-presented next cycle, so it never redirects now.
  assign d_redir = ~stall & (eret_D | taken);

  always_comb begin
    pc_d       = pc_q;
    pend_v_d   = pend_v_q;
    pend_tgt_d = pend_tgt_q;
    op_err_d   = op_err_q | npc_op_D[2];
    applied    = 1'b0;
    if (req) begin
      pc_d     = EXC_VEC;
      pend_v_d = 1'b0;
      applied  = 1'b1;
    end else if (advance) begin
      if (pend_v_q) begin
        pc_d     = pend_tgt_q;
        pend_v_d = 1'b0;
        applied  = 1'b1;
      end else if (d_redir) begin
        pc_d    = d_target;
        applied = 1'b1;
      end else begin
        pc_d = pc_q + 32'd4;
      end
    end else if (d_redir && !pend_v_q) begin
      pend_v_d   = 1'b1;
      pend_tgt_d = d_target;
    end
    cnt_d = (applied && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      pend_v_q   <= 1'b0;
      pend_tgt_q <= '0;
      op_err_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      pc_q       <= pc_d;
      pend_v_q   <= pend_v_d;
      pend_tgt_q <= pend_tgt_d;
      op_err_q   <= op_err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign pc_F         = pc_q;
  assign pend_v       = pend_v_q;
  assign op_err       = op_err_q;
  assign redirect_cnt = cnt_q;
  assign flush_F      = !DELAY_SLOT && imem_ack && (pend_v_q || d_redir);

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: one instance per DELAY_SLOT setting driven in lockstep.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_ack, stall, req, eret_D, cmp_true_D;
  logic [31:0] epc, instr_D, pc_D, rs_val_D;
  logic [2:0]  npc_op_D;
  logic [31:0] pc_F, pc_F0;
  logic        flush_F, flush_F0, pend_v, pend_v0, op_err, op_err0;
  logic [15:0] cnt, cnt0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pc_gen dut (
    .clk(clk), .reset(reset), .imem_ack(imem_ack), .stall(stall), .req(req),
    .eret_D(eret_D), .epc(epc), .npc_op_D(npc_op_D), .instr_D(instr_D),
    .pc_D(pc_D), .rs_val_D(rs_val_D), .cmp_true_D(cmp_true_D),
    .pc_F(pc_F), .flush_F(flush_F), .pend_v(pend_v), .op_err(op_err),
    .redirect_cnt(cnt)
  );

  pc_gen #(.DELAY_SLOT(1'b0)) dut0 (
    .clk(clk), .reset(reset), .imem_ack(imem_ack), .stall(stall), .req(req),
    .eret_D(eret_D), .epc(epc), .npc_op_D(npc_op_D), .instr_D(instr_D),
    .pc_D(pc_D), .rs_val_D(rs_val_D), .cmp_true_D(cmp_true_D),
    .pc_F(pc_F0), .flush_F(flush_F0), .pend_v(pend_v0), .op_err(op_err0),
    .redirect_cnt(cnt0)
  );

  typedef struct {
    logic        req, eret, stall, ack, cmp;
    logic [2:0]  op;
    logic [31:0] instr, pcd, rs, epc;
    logic        x_flush0;
    logic [31:0] x_pc;
    logic        x_pend, x_err;
    logic [15:0] x_cnt;
  } vec_t;

  vec_t vecs[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [31:0] xpc, input logic xpend,
                           input logic xerr, input logic [15:0] xcnt);
    chk({tag, " pc_F"}, pc_F, xpc);
    chk({tag, " pend_v"}, {31'd0, pend_v}, {31'd0, xpend});
    chk({tag, " op_err"}, {31'd0, op_err}, {31'd0, xerr});
    chk({tag, " cnt"}, {16'd0, cnt}, {16'd0, xcnt});
    chk({tag, " pc_F ds0"}, pc_F0, xpc);
  endtask

  task automatic drive(input vec_t v);
    req = v.req; eret_D = v.eret; stall = v.stall; imem_ack = v.ack;
    cmp_true_D = v.cmp; npc_op_D = v.op; instr_D = v.instr; pc_D = v.pcd;
    rs_val_D = v.rs; epc = v.epc;
  endtask

  function automatic vec_t mk(input logic rq, input logic er, input logic st, input logic ak,
                              input logic cp, input logic [2:0] op, input logic [31:0] ins,
                              input logic [31:0] pcd, input logic [31:0] rs, input logic [31:0] ep,
                              input logic f0, input logic [31:0] xpc, input logic xp,
                              input logic xe, input logic [15:0] xc);
    vec_t v;
    v.req = rq; v.eret = er; v.stall = st; v.ack = ak; v.cmp = cp; v.op = op;
    v.instr = ins; v.pcd = pcd; v.rs = rs; v.epc = ep;
    v.x_flush0 = f0; v.x_pc = xpc; v.x_pend = xp; v.x_err = xe; v.x_cnt = xc;
    return v;
  endfunction

  initial begin
    //            rq er st ak cp op    instr         pc_D          rs            epc           f0 pc            pd er cnt
    vecs[0]  = mk(0, 0, 0, 1, 0, 3'b000, 32'h0,        32'h0,        32'h0,        32'h0,        0, 32'h0000_3004, 0, 0, 16'd0);
    vecs[1]  = mk(0, 0, 0, 1, 0, 3'b000, 32'h0,        32'h0,        32'h0,        32'h0,        0, 32'h0000_3008, 0, 0, 16'd0);
    vecs[2]  = mk(0, 0, 0, 1, 0, 3'b000, 32'h0,        32'h0,        32'h0,        32'h0,        0, 32'h0000_300C, 0, 0, 16'd0);
    vecs[3]  = mk(0, 0, 0, 1, 1, 3'b001, 32'h0000_FFFE, 32'h0000_3010, 32'h0,       32'h0,        1, 32'h0000_300C, 0, 0, 16'd1);
    vecs[4]  = mk(0, 0, 0, 1, 0, 3'b001, 32'h0000_FFFE, 32'h0000_3010, 32'h0,       32'h0,        0, 32'h0000_3010, 0, 0, 16'd1);
    vecs[5]  = mk(0, 0, 0, 1, 0, 3'b010, 32'h0000_0100, 32'h3000_0010, 32'h0,       32'h0,        1, 32'h3000_0400, 0, 0, 16'd2);
    vecs[6]  = mk(0, 0, 0, 0, 0, 3'b011, 32'h0,        32'h0,        32'h0000_3400, 32'h0,        0, 32'h3000_0400, 1, 0, 16'd2);
    vecs[7]  = mk(0, 0, 0, 1, 0, 3'b000, 32'h0,        32'h0,        32'h0,        32'h0,        1, 32'h0000_3400, 0, 0, 16'd3);
    vecs[8]  = mk(0, 0, 0, 0, 0, 3'b011, 32'h0,        32'h0,        32'h0000_5000, 32'h0,        0, 32'h0000_3400, 1, 0, 16'd3);
    vecs[9]  = mk(0, 0, 0, 0, 0, 3'b011, 32'h0,        32'h0,        32'h0000_6000, 32'h0,        0, 32'h0000_3400, 1, 0, 16'd3);
    vecs[10] = mk(1, 0, 0, 0, 0, 3'b000, 32'h0,        32'h0,        32'h0,        32'h0,        0, 32'h0000_4180, 0, 0, 16'd4);
    vecs[11] = mk(0, 1, 0, 1, 0, 3'b010, 32'h0,        32'h0000_3010, 32'h0,       32'h0000_3020, 1, 32'h0000_3024, 0, 0, 16'd5);
    vecs[12] = mk(0, 1, 1, 1, 0, 3'b010, 32'h0,        32'h0000_3010, 32'h0,       32'h0000_3020, 0, 32'h0000_3024, 0, 0, 16'd5);
    vecs[13] = mk(0, 0, 1, 1, 0, 3'b011, 32'h0,        32'h0,        32'h0000_7000, 32'h0,        0, 32'h0000_3024, 0, 0, 16'd5);
    vecs[14] = mk(0, 0, 0, 1, 0, 3'b111, 32'h0,        32'h0,        32'h0,        32'h0,        0, 32'h0000_3028, 0, 1, 16'd5);
    vecs[15] = mk(0, 0, 0, 1, 0, 3'b000, 32'h0,        32'h0,        32'h0,        32'h0,        0, 32'h0000_302C, 0, 1, 16'd5);
    vecs[16] = mk(1, 0, 0, 1, 1, 3'b001, 32'h0000_FFFE, 32'h0000_3010, 32'h0,       32'h0,        1, 32'h0000_4180, 0, 1, 16'd6);
    vecs[17] = mk(0, 0, 0, 0, 0, 3'b011, 32'h0,        32'h0,        32'h0000_3400, 32'h0,        0, 32'h0000_4180, 1, 1, 16'd6);
    vecs[18] = mk(0, 0, 1, 1, 0, 3'b000, 32'h0,        32'h0,        32'h0,        32'h0,        1, 32'h0000_4180, 1, 1, 16'd6);
    vecs[19] = mk(0, 0, 0, 1, 0, 3'b011, 32'h0,        32'h0,        32'h0000_9000, 32'h0,        1, 32'h0000_3400, 0, 1, 16'd7);

    drive(mk(0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    reset = 1'b1;
    #12;
    chk_state("reset", 32'h0000_3000, 1'b0, 1'b0, 16'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 20; i++) begin
      drive(vecs[i]);
      #1;
      chk($sformatf("v%0d flush_F ds1", i), {31'd0, flush_F}, 32'd0);
      chk($sformatf("v%0d flush_F ds0", i), {31'd0, flush_F0}, {31'd0, vecs[i].x_flush0});
      @(posedge clk);
      #1;
      chk_state($sformatf("v%0d", i), vecs[i].x_pc, vecs[i].x_pend, vecs[i].x_err, vecs[i].x_cnt);
      @(negedge clk);
    end

    // Reset arriving while a redirect is pending must discard it.
    drive(mk(0, 0, 0, 0, 0, 3'b011, 0, 0, 32'h0000_3400, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    chk("pre-reset pend_v", {31'd0, pend_v}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk_state("mid reset", 32'h0000_3000, 1'b0, 1'b0, 16'd0);
    @(negedge clk);
    reset = 1'b0;
    drive(mk(0, 0, 0, 1, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    chk_state("post reset", 32'h0000_3004, 1'b0, 1'b0, 16'd0);

    // Counter saturation: one exception redirect per cycle.
    @(negedge clk);
    req = 1'b1;
    imem_ack = 1'b0;
    repeat (65535) @(posedge clk);
    #1;
    chk_state("sat", 32'h0000_4180, 1'b0, 1'b0, 16'hFFFF);
    @(posedge clk);
    #1;
    chk_state("sat hold", 32'h0000_4180, 1'b0, 1'b0, 16'hFFFF);
    chk("sat ds0 cnt", {16'd0, cnt0}, 32'h0000_FFFF);
    @(negedge clk);
    req = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
